// File: rtl/ahbl_sram_bist_master.sv
// AHB-Lite BIST master: writes an address-derived pattern over a word
// region, reads it back, and reports mismatches and bus errors.
module ahbl_sram_bist_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned NUM_WORDS = 512,
   parameter logic [31:0] SEED      = 32'hA5A5_5A5A
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] first_fail_addr,
   output logic        bus_err,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   output logic        HSEL,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   input  logic [31:0] HRDATA
);

   typedef enum logic [2:0] {
      IDLE, WR, WR_LAST, RD, RD_LAST, FIN
   } state_t;

   localparam logic [15:0] LAST = 16'(NUM_WORDS - 1);

   function automatic logic [31:0] pat(input logic [15:0] i);
      return {i, ~i} ^ SEED;
   endfunction

   function automatic logic [31:0] addr_of(input logic [15:0] i);
      return BASE_ADDR + {14'd0, i, 2'b00};
   endfunction

   state_t      state, state_nx;
   logic [15:0] cnt, cnt_nx;
   logic [15:0] dp_idx;
   logic        dp_vld;
   logic        abort_q;
   logic        pass_q;
   logic [31:0] hwdata_q;
   logic        issue, cmp, beat, err_hit, ok_now;
   logic        unused_hresp;

   assign unused_hresp = HRESP[1];

   assign busy    = state inside {WR, WR_LAST, RD, RD_LAST};
   assign done    = (state == FIN);
   assign ok_now  = (err_count == 16'd0) && !bus_err;
   assign pass    = done ? ok_now : pass_q;
   // First ERROR cycle: the slave holds HREADY low with HRESP[0] set.
   assign err_hit = busy && HRESP[0] && !HREADY;
   // Once aborted, nothing advances; only the closing HREADY matters.
   assign beat    = HREADY && !abort_q;

   assign HTRANS  = issue ? 2'b10 : 2'b00;
   assign HSEL    = HTRANS[1];
   assign HWRITE  = (state == WR);
   assign HADDR   = addr_of(cnt);
   assign HWDATA  = hwdata_q;
   assign HSIZE   = 3'b010;
   assign HBURST  = 3'b000;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      issue    = 1'b0;
      cmp      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = WR;
         end
         WR: begin
            issue = !abort_q;
            if (beat) begin
               if (cnt == LAST) state_nx = WR_LAST;
               else             cnt_nx   = cnt + 16'd1;
            end
         end
         WR_LAST: begin
            if (beat) begin
               state_nx = RD;
               cnt_nx   = 16'd0;
            end
         end
         RD: begin
            issue = !abort_q;
            cmp   = beat && dp_vld;
            if (beat) begin
               if (cnt == LAST) state_nx = RD_LAST;
               else             cnt_nx   = cnt + 16'd1;
            end
         end
         RD_LAST: begin
            cmp = beat && dp_vld;
            if (beat) state_nx = FIN;
         end
         FIN: begin
            state_nx = IDLE;
            cnt_nx   = 16'd0;
         end
         default: state_nx = IDLE;
      endcase
      if (abort_q && HREADY && busy) state_nx = FIN;
      if (err_hit) issue = 1'b0;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state           <= IDLE;
         cnt             <= 16'd0;
         dp_idx          <= 16'd0;
         dp_vld          <= 1'b0;
         abort_q         <= 1'b0;
         pass_q          <= 1'b0;
         hwdata_q        <= 32'd0;
         err_count       <= 16'd0;
         first_fail_addr <= 32'd0;
         bus_err         <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == IDLE && start) begin
            err_count       <= 16'd0;
            first_fail_addr <= 32'd0;
            pass_q          <= 1'b0;
            bus_err         <= 1'b0;
            abort_q         <= 1'b0;
         end
         if (state == WR && beat) hwdata_q <= pat(cnt);
         if (HREADY) dp_vld <= (state == RD) && !abort_q;
         if (state == RD && beat) dp_idx <= cnt;
         if (cmp && HRDATA != pat(dp_idx)) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) first_fail_addr <= addr_of(dp_idx);
         end
         if (err_hit) begin
            bus_err <= 1'b1;
            abort_q <= 1'b1;
         end
         if (state == FIN) begin
            pass_q  <= ok_now;
            abort_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahbl_sram_bist_master.sv
// Bench for ahbl_sram_bist_master: behavioural SRAM slave with wait,
// corruption and error injection, checked against a pattern model.
module tb_ahbl_sram_bist_master;

   localparam int          N    = 4;
   localparam logic [31:0] BASE = 32'h0;
   localparam logic [31:0] SEED = 32'hA5A5_5A5A;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, pass, bus_err, HWRITE, HSEL;
   logic [15:0] err_count;
   logic [31:0] first_fail_addr, HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic        HREADY = 1'b1;
   logic [1:0]  HRESP = 2'b00;
   logic [31:0] HRDATA = 32'd0;

   always #5 HCLK = ~HCLK;

   ahbl_sram_bist_master #(
      .BASE_ADDR(BASE), .NUM_WORDS(N), .SEED(SEED)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .start(start),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_addr(first_fail_addr),
      .bus_err(bus_err), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HWDATA(HWDATA), .HSEL(HSEL), .HREADY(HREADY),
      .HRESP(HRESP), .HRDATA(HRDATA)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // slave configuration (written only by the main sequence)
   int          waits = 0;
   bit          rand_wait = 1'b0;
   bit          err_on = 1'b0;
   logic [31:0] err_addr = 32'd0;
   logic [31:0] corrupt [0:15];
   bit          check_hold = 1'b0;

   logic [31:0] mem [0:15];
   logic [1:0]  sn_trans;
   logic [31:0] sn_addr, sn_wdata;
   logic        sn_write;

   // monitor counters (written only by the monitor)
   int n_wr = 0, n_rd = 0, n_done = 0, n_hold = 0;
   int n_errc = 0, n_errbad = 0;
   logic [31:0] wr_addr_q [$];
   logic        p_ready = 1'b1;
   logic [31:0] p_addr, p_wdata;
   logic [1:0]  p_trans;
   logic        p_write;

   // baselines taken at the start of each run
   int b_wr, b_rd, b_done, b_hold, b_errc, b_errbad, b_q;

   function automatic logic [31:0] pat(input int i);
      logic [15:0] k;
      k = 16'(i);
      return {k, ~k} ^ SEED;
   endfunction

   // Bus monitor: samples mid-cycle, when every signal has settled.
   initial begin
      forever begin
         @(negedge HCLK);
         if (!HRESET) begin
            if (check_hold && !p_ready &&
                (HADDR !== p_addr || HTRANS !== p_trans ||
                 HWRITE !== p_write || HWDATA !== p_wdata))
               n_hold++;
            if (HTRANS == 2'b10 && HREADY) begin
               if (HWRITE) begin
                  n_wr++;
                  wr_addr_q.push_back(HADDR);
               end else begin
                  n_rd++;
               end
            end
            if (done) n_done++;
            if (HRESP[0] && !HREADY) begin
               n_errc++;
               if (HTRANS !== 2'b00) n_errbad++;
            end
         end
         p_ready  = HREADY;
         p_addr   = HADDR;
         p_trans  = HTRANS;
         p_write  = HWRITE;
         p_wdata  = HWDATA;
         sn_trans = HTRANS;
         sn_addr  = HADDR;
         sn_write = HWRITE;
         sn_wdata = HWDATA;
      end
   end

   // SRAM slave model
   bit          s_dp = 1'b0, s_wr = 1'b0;
   logic [31:0] s_addr = 32'd0;
   int          s_wl = 0, s_err = 0;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      forever begin
         @(posedge HCLK);
         if (HRESET) begin
            s_dp = 1'b0;
            s_err = 0;
            s_wl = 0;
            HREADY <= 1'b1;
            HRESP <= 2'b00;
         end else begin
            if (HREADY) begin
               if (s_dp && s_wr && s_err == 0) mem[s_addr[5:2]] = sn_wdata;
               s_dp   = sn_trans[1];
               s_addr = sn_addr;
               s_wr   = sn_write;
               s_wl   = rand_wait ? int'($urandom_range(0, 2)) : waits;
               s_err  = (s_dp && err_on && s_wr && s_addr == err_addr) ? 1 : 0;
            end
            if (!s_dp) begin
               HREADY <= 1'b1;
               HRESP <= 2'b00;
            end else if (s_err == 1) begin
               HREADY <= 1'b0;
               HRESP <= 2'b01;
               s_err = 2;
            end else if (s_err == 2) begin
               HREADY <= 1'b1;
               HRESP <= 2'b01;
               s_err = 3;
            end else if (s_wl > 0) begin
               HREADY <= 1'b0;
               HRESP <= 2'b00;
               s_wl--;
            end else begin
               HREADY <= 1'b1;
               HRESP <= 2'b00;
               if (!s_wr) HRDATA <= mem[s_addr[5:2]] ^ corrupt[s_addr[5:2]];
            end
         end
      end
   end

   task automatic take_base();
      @(posedge HCLK);
      b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_hold = n_hold;
      b_errc = n_errc; b_errbad = n_errbad; b_q = wr_addr_q.size();
   endtask

   task automatic settle();
      repeat (3) @(negedge HCLK);
      @(posedge HCLK);
   endtask

   // Starts a test and returns at the negedge where done is seen.
   task automatic run_bist(input int repulse, output int cyc);
      take_base();
      @(negedge HCLK);
      start = 1'b1;
      @(negedge HCLK);
      cyc = 1;
      while (done !== 1'b1 && cyc < 600) begin
         start = (cyc == repulse);
         @(negedge HCLK);
         cyc++;
      end
      start = 1'b0;
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL done_timeout: got no done after %0d cycles", cyc);
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if ({busy, done, pass, bus_err, err_count, first_fail_addr,
           HTRANS, HWRITE, HWDATA, HSEL} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%b done=%b pass=%b be=%b ec=%h ffa=%h tr=%b wr=%b wd=%h, want all 0",
                  busy, done, pass, bus_err, err_count, first_fail_addr, HTRANS, HWRITE, HWDATA);
      end
      tests_run++;
      if (HADDR !== BASE) begin
         tests_failed++;
         $display("FAIL reset_haddr: got %h want %h", HADDR, BASE);
      end
      tests_run++;
      if (HSIZE !== 3'b010 || HBURST !== 3'b000) begin
         tests_failed++;
         $display("FAIL const_size_burst: got %b/%b want 010/000", HSIZE, HBURST);
      end
      HRESET = 1'b0;
      repeat (2) @(negedge HCLK);
      tests_run++;
      if ({busy, done, HTRANS, HADDR} !== {1'b0, 1'b0, 2'b00, BASE}) begin
         tests_failed++;
         $display("FAIL idle_after_reset: got busy=%b done=%b tr=%b addr=%h", busy, done, HTRANS, HADDR);
      end
   endtask

   task automatic test_zero_wait();
      int cyc;
      run_bist(0, cyc);
      tests_run++;
      if (cyc !== 2 * N + 3) begin
         tests_failed++;
         $display("FAIL zw_done_cycle: got %0d want %0d", cyc, 2 * N + 3);
      end
      tests_run++;
      if ({pass, bus_err, err_count, first_fail_addr, busy} !== {1'b1, 1'b0, 16'd0, 32'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL zw_result: got pass=%b be=%b ec=%0d ffa=%h busy=%b want 1/0/0/0/0",
                  pass, bus_err, err_count, first_fail_addr, busy);
      end
      settle();
      tests_run++;
      if (n_wr - b_wr !== N || n_rd - b_rd !== N) begin
         tests_failed++;
         $display("FAIL zw_transfers: got wr=%0d rd=%0d want %0d each", n_wr - b_wr, n_rd - b_rd, N);
      end
      for (int i = 0; i < N; i++) begin
         tests_run++;
         if (wr_addr_q.size() <= b_q + i || wr_addr_q[b_q + i] !== BASE + 32'(4 * i)) begin
            tests_failed++;
            $display("FAIL zw_wr_addr%0d: got %h want %h", i,
                     (wr_addr_q.size() > b_q + i) ? wr_addr_q[b_q + i] : 32'hx, BASE + 32'(4 * i));
         end
         tests_run++;
         if (mem[i] !== pat(i)) begin
            tests_failed++;
            $display("FAIL zw_mem%0d: got %h want %h", i, mem[i], pat(i));
         end
      end
      tests_run++;
      if (n_done - b_done !== 1 || pass !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL zw_after_done: got dones=%0d pass=%b done=%b want 1/1/0", n_done - b_done, pass, done);
      end
   endtask

   task automatic test_wait_states();
      int cyc;
      waits = 2;
      check_hold = 1'b1;
      run_bist(0, cyc);
      tests_run++;
      if (cyc !== 2 * N + 3 + 2 * 2 * N) begin
         tests_failed++;
         $display("FAIL ws_done_cycle: got %0d want %0d", cyc, 2 * N + 3 + 4 * N);
      end
      tests_run++;
      if (pass !== 1'b1 || err_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL ws_result: got pass=%b ec=%0d want 1/0", pass, err_count);
      end
      settle();
      tests_run++;
      if ((n_wr - b_wr) + (n_rd - b_rd) !== 2 * N || n_hold - b_hold !== 0) begin
         tests_failed++;
         $display("FAIL ws_transfers_hold: got xfers=%0d holdviol=%0d want %0d/0",
                  (n_wr - b_wr) + (n_rd - b_rd), n_hold - b_hold, 2 * N);
      end
      waits = 0;
      check_hold = 1'b0;
   endtask

   task automatic run_corrupt(input logic [3:0] m, input string nm);
      int cyc, exp_cnt, exp_first;
      exp_cnt = 0;
      exp_first = -1;
      for (int i = 0; i < 16; i++) corrupt[i] = 32'd0;
      for (int i = 0; i < N; i++) begin
         if (m[i]) begin
            corrupt[i] = $urandom | 32'h1;
            exp_cnt++;
            if (exp_first < 0) exp_first = i;
         end
      end
      run_bist(0, cyc);
      tests_run++;
      if (err_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL %s_count: got %0d want %0d", nm, err_count, exp_cnt);
      end
      tests_run++;
      if (first_fail_addr !== ((exp_first < 0) ? 32'd0 : BASE + 32'(4 * exp_first))) begin
         tests_failed++;
         $display("FAIL %s_first: got %h want index %0d", nm, first_fail_addr, exp_first);
      end
      tests_run++;
      if (pass !== (exp_cnt == 0)) begin
         tests_failed++;
         $display("FAIL %s_pass: got %b want %b", nm, pass, exp_cnt == 0);
      end
      for (int i = 0; i < 16; i++) corrupt[i] = 32'd0;
   endtask

   task automatic test_corrupt();
      run_corrupt(4'b0100, "cor_w2");
      run_corrupt(4'b1010, "cor_w13");
   endtask

   task automatic test_random();
      rand_wait = 1'b1;
      check_hold = 1'b1;
      for (int it = 0; it < 6; it++) begin
         run_corrupt(4'($urandom_range(0, 15)), "rnd");
         settle();
         tests_run++;
         if (n_hold - b_hold !== 0) begin
            tests_failed++;
            $display("FAIL rnd_hold: got %0d violations want 0", n_hold - b_hold);
         end
      end
      rand_wait = 1'b0;
      check_hold = 1'b0;
   endtask

   task automatic test_bus_error();
      int cyc;
      err_on = 1'b1;
      err_addr = BASE + 32'h8;
      run_bist(0, cyc);
      tests_run++;
      if (cyc !== 6) begin
         tests_failed++;
         $display("FAIL be_done_cycle: got %0d want 6", cyc);
      end
      tests_run++;
      if (bus_err !== 1'b1 || pass !== 1'b0 || err_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL be_result: got be=%b pass=%b ec=%0d want 1/0/0", bus_err, pass, err_count);
      end
      settle();
      tests_run++;
      if (n_errc - b_errc !== 1 || n_errbad - b_errbad !== 0) begin
         tests_failed++;
         $display("FAIL be_htrans_idle: got errcycles=%0d nonidle=%0d want 1/0",
                  n_errc - b_errc, n_errbad - b_errbad);
      end
      tests_run++;
      if (n_wr - b_wr !== 3 || n_rd - b_rd !== 0 || n_done - b_done !== 1) begin
         tests_failed++;
         $display("FAIL be_transfers: got wr=%0d rd=%0d dones=%0d want 3/0/1",
                  n_wr - b_wr, n_rd - b_rd, n_done - b_done);
      end
      err_on = 1'b0;
   endtask

   task automatic test_reset_mid();
      int k, cyc;
      take_base();
      @(negedge HCLK);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      k = 0;
      while (!(HTRANS == 2'b10 && !HWRITE && HADDR == BASE + 32'h4) && k < 100) begin
         @(negedge HCLK);
         k++;
      end
      tests_run++;
      if (k >= 100) begin
         tests_failed++;
         $display("FAIL rm_reach_rd1: got no read of word 1 within %0d cycles", k);
      end
      HRESET = 1'b1;
      #1;
      tests_run++;
      if (HTRANS !== 2'b00 || HSEL !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rm_async: got tr=%b sel=%b busy=%b want 00/0/0", HTRANS, HSEL, busy);
      end
      @(negedge HCLK);
      tests_run++;
      if ({busy, done, pass, bus_err, err_count, first_fail_addr, HTRANS, HWRITE, HWDATA, HADDR}
          !== {1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 2'b00, 1'b0, 32'd0, BASE}) begin
         tests_failed++;
         $display("FAIL rm_reset_values: got busy=%b done=%b ec=%0d wd=%h addr=%h",
                  busy, done, err_count, HWDATA, HADDR);
      end
      HRESET = 1'b0;
      @(posedge HCLK);
      tests_run++;
      if (n_done - b_done !== 0) begin
         tests_failed++;
         $display("FAIL rm_no_done: got %0d done pulses want 0", n_done - b_done);
      end
      repeat (2) @(negedge HCLK);
      run_bist(0, cyc);
      tests_run++;
      if (pass !== 1'b1 || err_count !== 16'd0 || cyc !== 2 * N + 3) begin
         tests_failed++;
         $display("FAIL rm_rerun: got pass=%b ec=%0d cyc=%0d want 1/0/%0d", pass, err_count, cyc, 2 * N + 3);
      end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      run_bist(2, cyc);
      tests_run++;
      if (pass !== 1'b1 || cyc !== 2 * N + 3) begin
         tests_failed++;
         $display("FAIL sb_result: got pass=%b cyc=%0d want 1/%0d", pass, cyc, 2 * N + 3);
      end
      repeat (6) @(negedge HCLK);
      @(posedge HCLK);
      tests_run++;
      if ((n_wr - b_wr) + (n_rd - b_rd) !== 2 * N || n_done - b_done !== 1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_ignored: got xfers=%0d dones=%0d busy=%b want %0d/1/0",
                  (n_wr - b_wr) + (n_rd - b_rd), n_done - b_done, busy, 2 * N);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) corrupt[i] = 32'd0;
      repeat (3) @(negedge HCLK);
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_corrupt();
      test_random();
      test_bus_error();
      test_reset_mid();
      test_start_while_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
